uart_tx_fsm: RTL and testbench

Control state machine for the UART transmitter. It accepts a byte-valid strobe and sequences one frame: start bit, serial data, optional parity, then 1 or 2 stop bits. It drives the serializer enable (which also gates the serializer's bit counter), the serializer load strobe, the output-mux select and a busy flag. It sits between the host-side data interface and the serializer / parity / output-mux datapath.

---
 rtl/uart_tx_pkg.sv | 48 ++++
 rtl/uart_tx_fsm_if.sv | 49 ++++
 rtl/uart_tx_fsm.sv | 134 +++++++++++++
 tb/tb_uart_tx_fsm.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared definitions for the UART transmitter control path.
//                State encodings, output-mux select codes and a helper that
//                maps a state to the line select it drives.
//  Contents    : C_* state encodings, tx_state_e enum, SEL_* mux codes,
//                sel_of_state() decode function.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  // State encodings, shared by every block that needs to decode FSM state
  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_START  = 3'd1;
  localparam logic [2:0] C_DATA   = 3'd2;
  localparam logic [2:0] C_PARITY = 3'd3;
  localparam logic [2:0] C_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = C_IDLE,
    S_START  = C_START,
    S_DATA   = C_DATA,
    S_PARITY = C_PARITY,
    S_STOP   = C_STOP
  } tx_state_e;

  // Output-mux select codes: which source drives the serial line
  localparam logic [1:0] SEL_START = 2'b00;  // constant 0
  localparam logic [1:0] SEL_DATA  = 2'b01;  // serializer output
  localparam logic [1:0] SEL_PAR   = 2'b10;  // parity bit
  localparam logic [1:0] SEL_STOP  = 2'b11;  // constant 1 (stop and idle)

  // Line select driven while the FSM sits in a given state. Unknown
  // encodings fall back to the idle level so the line never glitches low.
  function automatic logic [1:0] sel_of_state(input tx_state_e s);
    logic [1:0] sel;
    case (s)
      S_START:  sel = SEL_START;
      S_DATA:   sel = SEL_DATA;
      S_PARITY: sel = SEL_PAR;
      default:  sel = SEL_STOP;
    endcase
    return sel;
  endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fsm_if
//  Description : Handshake bundle between the UART TX control FSM and its
//                surroundings (host strobe, serializer, parity, output mux).
//  Signals     : tx_fsm_Data_Valid - host strobe, new byte present
//                tx_fsm_PAR_EN     - parity enable, sampled at accept
//                tx_fsm_ser_done   - serializer counter reached all-ones
//                tx_fsm_ser_en     - serializer shift / counter enable
//                tx_fsm_load       - serializer / parity capture strobe
//                tx_fsm_mux_sel    - output line select (2 bits)
//                tx_fsm_busy       - frame in progress
//  Modports    : master - host/datapath side, slave - FSM side
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fsm_if;

  logic       tx_fsm_Data_Valid;
  logic       tx_fsm_PAR_EN;
  logic       tx_fsm_ser_done;
  logic       tx_fsm_ser_en;
  logic       tx_fsm_load;
  logic [1:0] tx_fsm_mux_sel;
  logic       tx_fsm_busy;

  // Host and datapath: supply strobe, parity enable and serializer status
  modport master (
    output tx_fsm_Data_Valid,
    output tx_fsm_PAR_EN,
    output tx_fsm_ser_done,
    input  tx_fsm_ser_en,
    input  tx_fsm_load,
    input  tx_fsm_mux_sel,
    input  tx_fsm_busy
  );

  // Control FSM
  modport slave (
    input  tx_fsm_Data_Valid,
    input  tx_fsm_PAR_EN,
    input  tx_fsm_ser_done,
    output tx_fsm_ser_en,
    output tx_fsm_load,
    output tx_fsm_mux_sel,
    output tx_fsm_busy
  );

endinterface : uart_tx_fsm_if
`default_nettype wire

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fsm
//  Description : UART transmitter control state machine. Accepts a byte-valid
//                strobe and sequences one frame: start bit, DATA_WIDTH data
//                bits (paced by the serializer's done flag), optional parity
//                bit, then STOP_BITS stop bits.
//  Ports       : tx_fsm_CLK      - clock, rising edge
//                tx_fsm_RST_ASYN - asynchronous active-low reset
//                bus (slave)     - strobe / parity enable / ser_done in,
//                                  ser_en / load / mux_sel / busy out
//  Parameters  : DATA_WIDTH - data bits per frame, power of two
//                STOP_BITS  - stop bits per frame, 1 or 2
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  wire logic     tx_fsm_CLK,
  input  wire logic     tx_fsm_RST_ASYN,
  uart_tx_fsm_if.slave  bus
);

  // The serializer raises done when its counter is all-ones, which only
  // marks the last data bit when DATA_WIDTH is a power of two.
  if (DATA_WIDTH < 2 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
    $error("uart_tx_fsm: DATA_WIDTH must be a power of two >= 2");
  end

  // The stop counter is a single bit, so only one or two stop bits fit.
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fsm: STOP_BITS must be 1 or 2");
  end

  // Stop-counter value on the final stop bit
  localparam logic C_STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  tx_state_e  state_q,     state_d;
  logic       par_latch_q, par_latch_d;
  logic       stop_cnt_q,  stop_cnt_d;

  logic [1:0] mux_sel_q;
  logic       busy_q;
  logic       ser_en_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    par_latch_d = par_latch_q;
    stop_cnt_d  = stop_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.tx_fsm_Data_Valid) begin
          // Parity enable is frozen here; later changes on the port are
          // invisible to the rest of the frame.
          par_latch_d = bus.tx_fsm_PAR_EN;
          state_d     = S_START;
        end
      end

      S_START: begin
        state_d = S_DATA;
      end

      S_DATA: begin
        // Dwell is set by the serializer, not by a local count.
        if (bus.tx_fsm_ser_done) begin
          state_d = par_latch_q ? S_PARITY : S_STOP;
        end
      end

      S_PARITY: begin
        state_d = S_STOP;
      end

      S_STOP: begin
        if (stop_cnt_q == C_STOP_LAST) begin
          stop_cnt_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d    = S_IDLE;
        stop_cnt_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers. The Moore outputs are registered from the
  // decode of the next state, so they change on the same edge as the state
  // register and carry no combinational decode path to the pins.
  // --------------------------------------------------------------------------
  always_ff @(posedge tx_fsm_CLK or negedge tx_fsm_RST_ASYN) begin
    if (!tx_fsm_RST_ASYN) begin
      state_q     <= S_IDLE;
      par_latch_q <= 1'b0;
      stop_cnt_q  <= 1'b0;
      mux_sel_q   <= SEL_STOP;
      busy_q      <= 1'b0;
      ser_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      par_latch_q <= par_latch_d;
      stop_cnt_q  <= stop_cnt_d;
      mux_sel_q   <= sel_of_state(state_d);
      busy_q      <= (state_d != S_IDLE);
      // Dropping the enable outside DATA lets the serializer counter clear
      // itself between frames.
      ser_en_q    <= (state_d == S_DATA);
    end
  end

  assign bus.tx_fsm_mux_sel = mux_sel_q;
  assign bus.tx_fsm_busy    = busy_q;
  assign bus.tx_fsm_ser_en  = ser_en_q;

  // Load is Mealy so the datapath captures the byte in the accept cycle
  // itself. It is qualified with reset so it is low while reset is held.
  assign bus.tx_fsm_load = tx_fsm_RST_ASYN
                         & (state_q == S_IDLE)
                         & bus.tx_fsm_Data_Valid;

endmodule : uart_tx_fsm
`default_nettype wire

// File: tb/tb_uart_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fsm
//  Description : Scoreboard testbench for uart_tx_fsm. Two instances are
//                driven: one with one stop bit, one with two. Each cycle the
//                driver pushes the expected {mux_sel, busy, ser_en, load}
//                observation per instance; monitors pop and compare on the
//                falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fsm;

  typedef struct packed {
    logic [1:0] sel;
    logic       busy;
    logic       en;
    logic       load;
  } obs_t;

  // Expected observations: {sel, busy, ser_en, load}
  localparam obs_t E_IDLE  = 5'b11_000;
  localparam obs_t E_ACC   = 5'b11_001;
  localparam obs_t E_START = 5'b00_100;
  localparam obs_t E_DATA  = 5'b01_110;
  localparam obs_t E_PAR   = 5'b10_100;
  localparam obs_t E_STOP  = 5'b11_100;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  obs_t exp1[$];
  obs_t exp2[$];

  uart_tx_fsm_if bus1();
  uart_tx_fsm_if bus2();

  uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .tx_fsm_CLK      (clk),
    .tx_fsm_RST_ASYN (rst_n),
    .bus             (bus1)
  );

  uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .tx_fsm_CLK      (clk),
    .tx_fsm_RST_ASYN (rst_n),
    .bus             (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer models: 3-bit counter enabled by ser_en, done at all-ones
  logic [2:0] cnt1, cnt2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1 <= 3'd0;
      cnt2 <= 3'd0;
    end else begin
      cnt1 <= bus1.tx_fsm_ser_en ? cnt1 + 3'd1 : 3'd0;
      cnt2 <= bus2.tx_fsm_ser_en ? cnt2 + 3'd1 : 3'd0;
    end
  end
  assign bus1.tx_fsm_ser_done = bus1.tx_fsm_ser_en && (cnt1 == 3'd7);
  assign bus2.tx_fsm_ser_done = bus2.tx_fsm_ser_en && (cnt2 == 3'd7);

  // Monitors
  int cyc1 = 0;
  int cyc2 = 0;
  always @(negedge clk) begin
    if (exp1.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp1.pop_front();
      a = {bus1.tx_fsm_mux_sel, bus1.tx_fsm_busy, bus1.tx_fsm_ser_en, bus1.tx_fsm_load};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL dut1_obs cycle=%0d got sel=%b busy=%b en=%b load=%b expected sel=%b busy=%b en=%b load=%b",
                 cyc1, a.sel, a.busy, a.en, a.load, e.sel, e.busy, e.en, e.load);
      end
      cyc1++;
    end
  end

  always @(negedge clk) begin
    if (exp2.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp2.pop_front();
      a = {bus2.tx_fsm_mux_sel, bus2.tx_fsm_busy, bus2.tx_fsm_ser_en, bus2.tx_fsm_load};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL dut2_obs cycle=%0d got sel=%b busy=%b en=%b load=%b expected sel=%b busy=%b en=%b load=%b",
                 cyc2, a.sel, a.busy, a.en, a.load, e.sel, e.busy, e.en, e.load);
      end
      cyc2++;
    end
  end

  // One cycle of stimulus for both instances plus the expected observations
  task automatic step(input logic rst, input logic dv1, input logic p1, input obs_t e1,
                      input logic dv2, input logic p2, input obs_t e2);
    rst_n                  = rst;
    bus1.tx_fsm_Data_Valid = dv1;
    bus1.tx_fsm_PAR_EN     = p1;
    bus2.tx_fsm_Data_Valid = dv2;
    bus2.tx_fsm_PAR_EN     = p2;
    exp1.push_back(e1);
    exp2.push_back(e2);
    @(posedge clk);
    #1;
  endtask

  // Stimulus on one instance while the other idles
  task automatic fstep(input bit on2, input logic dv, input logic p, input obs_t e);
    if (on2) step(1'b1, 1'b0, 1'b0, E_IDLE, dv, p, e);
    else     step(1'b1, dv, p, e, 1'b0, 1'b0, E_IDLE);
  endtask

  // Full frame: accept, start, 8 data, optional parity, nstop stops, 1 idle.
  // With toggle set, PAR_EN flips from the 4th data cycle onward.
  task automatic frame(input bit on2, input logic par, input bit toggle);
    int nstop;
    nstop = on2 ? 2 : 1;
    fstep(on2, 1'b1, par, E_ACC);
    fstep(on2, 1'b0, par, E_START);
    for (int k = 0; k < 8; k++) begin
      fstep(on2, 1'b0, (toggle && k >= 3) ? ~par : par, E_DATA);
    end
    if (par) fstep(on2, 1'b0, 1'b0, E_PAR);
    for (int s = 0; s < nstop; s++) fstep(on2, 1'b0, 1'b0, E_STOP);
    fstep(on2, 1'b0, 1'b0, E_IDLE);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus1.tx_fsm_Data_Valid = 1'b0;
    bus1.tx_fsm_PAR_EN     = 1'b0;
    bus2.tx_fsm_Data_Valid = 1'b0;
    bus2.tx_fsm_PAR_EN     = 1'b0;
    @(posedge clk);
    #1;

    // Reset held, then 5 idle cycles
    step(1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 1'b0, E_IDLE);
    step(1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 1'b0, E_IDLE);
    for (int i = 0; i < 5; i++) fstep(1'b0, 1'b0, 1'b0, E_IDLE);

    // Frame without parity
    frame(1'b0, 1'b0, 1'b0);
    // Frame with parity, PAR_EN dropped mid-DATA
    frame(1'b0, 1'b1, 1'b1);
    // Two stop bits with parity
    frame(1'b1, 1'b1, 1'b0);
    // Two stop bits without parity, PAR_EN raised mid-DATA
    frame(1'b1, 1'b0, 1'b1);

    // Data_Valid held: 11-cycle period, accept only in the single IDLE cycle
    for (int i = 0; i < 34; i++) begin
      obs_t e;
      int   ph;
      ph = i % 11;
      if (ph == 0)      e = (i < 30) ? E_ACC : E_IDLE;
      else if (ph == 1) e = E_START;
      else if (ph <= 9) e = E_DATA;
      else              e = E_STOP;
      fstep(1'b0, (i < 30) ? 1'b1 : 1'b0, 1'b0, e);
    end

    // Reset asserted on the 4th DATA cycle
    fstep(1'b0, 1'b1, 1'b1, E_ACC);
    fstep(1'b0, 1'b0, 1'b0, E_START);
    for (int k = 0; k < 3; k++) fstep(1'b0, 1'b0, 1'b0, E_DATA);
    step(1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 1'b0, E_IDLE);
    step(1'b0, 1'b0, 1'b0, E_IDLE, 1'b0, 1'b0, E_IDLE);
    for (int i = 0; i < 3; i++) fstep(1'b0, 1'b0, 1'b0, E_IDLE);
    // Clean frame after reset; parity latch must have been cleared
    frame(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp1.size() != 0 || exp2.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending1=%0d pending2=%0d expected 0",
               exp1.size(), exp2.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_tx_fsm
`default_nettype wire
